// File: rtl/aes_round_key_sched.sv
// Drives an external key_expansion block round by round and stores the 11 AES-128 round keys for indexed readback.
// Latency: (EXP_LATENCY+1) cycles per round, 1-cycle registered read; start is ignored while busy, with no other backpressure.
module aes_round_key_sched #(
   parameter int EXP_LATENCY = 1,
   parameter int NUM_ROUNDS  = 10
) (
   input  logic         CLK,
   input  logic         reset,
   input  logic         start,
   input  logic [127:0] key_in,
   output logic         busy,
   output logic         keys_ready,
   output logic         done,
   input  logic [3:0]   rk_idx,
   output logic [127:0] rk_out,
   output logic [127:0] exp_key_in,
   output logic [7:0]   exp_rcon,
   input  logic [127:0] exp_key_out
);

   localparam int CW = (EXP_LATENCY > 0) ? $clog2(EXP_LATENCY + 1) : 1;
   localparam int RW = $clog2(NUM_ROUNDS + 1);

   typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [RW-1:0]   round;
   logic            done_q;
   logic            capture;
   logic            last_round;
   logic            accept;
   logic [127:0]    rk [NUM_ROUNDS+1];

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   assign accept     = (state != EXPAND) && start;
   assign capture    = (state == EXPAND) && (cnt == CW'(EXP_LATENCY));
   assign last_round = (round == RW'(NUM_ROUNDS));

   always_ff @(posedge CLK) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, READY: if (start) state_nxt = EXPAND;
         EXPAND:      if (capture && last_round) state_nxt = READY;
         default:     state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy       = (state == EXPAND);
      keys_ready = (state == READY);
      done       = done_q;
   end

   // Each captured key is fed straight back as the next round's input.
   always_ff @(posedge CLK) begin
      if (reset) begin
         exp_key_in <= '0;
         exp_rcon   <= 8'h01;
         round      <= '0;
         cnt        <= '0;
         done_q     <= 1'b0;
         rk_out     <= '0;
      end else begin
         done_q <= 1'b0;
         rk_out <= (keys_ready && (rk_idx <= 4'(NUM_ROUNDS))) ? rk[rk_idx] : '0;
         if (accept) begin
            exp_key_in <= key_in;
            exp_rcon   <= 8'h01;
            round      <= RW'(1);
            cnt        <= '0;
         end else if (capture) begin
            exp_key_in <= exp_key_out;
            exp_rcon   <= xtime(exp_rcon);
            round      <= round + RW'(1);
            cnt        <= '0;
            done_q     <= last_round;
         end else if (state == EXPAND) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

   // Store is not reset; keys_ready gates every read.
   always_ff @(posedge CLK) begin
      if (!reset) begin
         if (accept)       rk[0]     <= key_in;
         else if (capture) rk[round] <= exp_key_out;
      end
   end

endmodule

// File: tb/tb_aes_round_key_sched.sv
// Directed bench: two sequencers (registered and combinational expansion models) checked against known AES-128 round keys.
module tb_aes_round_key_sched;

   localparam logic [127:0] K1     = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] K1_R1  = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
   localparam logic [127:0] K1_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] K2_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

   logic CLK = 1'b0;
   logic reset;
   always #5 CLK = ~CLK;

   logic         start1, busy1, keys_ready1, done1;
   logic [127:0] key1, rk_out1, exp_key_in1, exp_key_out1;
   logic [3:0]   rk_idx1;
   logic [7:0]   exp_rcon1;

   logic         start0, busy0, keys_ready0, done0;
   logic [127:0] key0, rk_out0, exp_key_in0, exp_key_out0;
   logic [3:0]   rk_idx0;
   logic [7:0]   exp_rcon0;

   int errors = 0;
   int checks = 0;

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p  = 8'h00;
      logic [7:0] aa = a;
      logic [7:0] bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b = 8'h01;
      for (int i = 0; i < 254; i++) b = gmul(b, x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   // One AES-128 key-expansion round, standing in for the upstream key_expansion block.
   function automatic logic [127:0] ke(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3, t;
      w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
      t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      return {w0, w1, w2, w3};
   endfunction

   always_ff @(posedge CLK) exp_key_out1 <= ke(exp_key_in1, exp_rcon1);
   always_comb exp_key_out0 = ke(exp_key_in0, exp_rcon0);

   aes_round_key_sched #(.EXP_LATENCY(1), .NUM_ROUNDS(10)) dut1 (
      .CLK(CLK), .reset(reset), .start(start1), .key_in(key1),
      .busy(busy1), .keys_ready(keys_ready1), .done(done1),
      .rk_idx(rk_idx1), .rk_out(rk_out1),
      .exp_key_in(exp_key_in1), .exp_rcon(exp_rcon1), .exp_key_out(exp_key_out1)
   );

   aes_round_key_sched #(.EXP_LATENCY(0), .NUM_ROUNDS(10)) dut0 (
      .CLK(CLK), .reset(reset), .start(start0), .key_in(key0),
      .busy(busy0), .keys_ready(keys_ready0), .done(done0),
      .rk_idx(rk_idx0), .rk_out(rk_out0),
      .exp_key_in(exp_key_in0), .exp_rcon(exp_rcon0), .exp_key_out(exp_key_out0)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Counts cycles from the accepting edge until done rises; an expired bound is a failure.
   task automatic wait_done(input bit lat1, output int cyc);
      cyc = 0;
      while (cyc < 60) begin
         tick();
         cyc++;
         if (lat1 ? done1 : done0) break;
      end
      if (cyc >= 60) check("done_timeout", 0, 1);
   endtask

   task automatic read1(input logic [3:0] idx, input string tag, input logic [127:0] exp);
      rk_idx1 = idx;
      tick();
      check(tag, rk_out1, exp);
   endtask

   logic [7:0] rcon_seq [10];
   int         cyc;

   initial begin
      rcon_seq = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
      reset = 1'b1;
      start1 = 1'b0; key1 = '0; rk_idx1 = '0;
      start0 = 1'b0; key0 = '0; rk_idx0 = '0;
      tick();
      tick();
      check("rst_busy", busy1, 0);
      check("rst_ready", keys_ready1, 0);
      check("rst_done", done1, 0);
      check("rst_rk_out", rk_out1, 0);
      check("rst_exp_key", exp_key_in1, 0);
      check("rst_rcon", exp_rcon1, 8'h01);
      reset = 1'b0;
      tick();

      // Full expansion of K1 with per-cycle rcon and done monitoring
      key1 = K1; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("t1_busy", busy1, 1);
      check("t1_exp_key_in", exp_key_in1, K1);
      for (int i = 0; i < 20; i++) begin
         check($sformatf("t1_rcon_%0d", i), exp_rcon1, rcon_seq[i/2]);
         check($sformatf("t1_nodone_%0d", i), done1, 0);
         tick();
      end
      check("t1_done", done1, 1);
      check("t1_ready", keys_ready1, 1);
      check("t1_busy_end", busy1, 0);
      tick();
      check("t1_done_pulse", done1, 0);
      check("t1_ready_hold", keys_ready1, 1);

      read1(4'd0, "t2_rk0", K1);
      rk_idx1 = 4'd1;
      #1;
      check("t2_read_latency", rk_out1, K1);
      tick();
      check("t2_rk1", rk_out1, K1_R1);
      read1(4'd10, "t2_rk10", K1_R10);

      // Restart from READY with K2; a second start mid-expansion must be ignored
      key1 = K2; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      rk_idx1 = 4'd0;
      cyc = 0;
      while (!done1 && cyc < 60) begin
         if (cyc == 3) check("t4_read_during_expand", rk_out1, 0);
         if (cyc == 4) begin start1 = 1'b1; key1 = K1; end
         else start1 = 1'b0;
         tick();
         cyc++;
      end
      start1 = 1'b0;
      check("t4_done_cycles", cyc, 20);
      read1(4'd10, "t4_rk10", K2_R10);
      read1(4'd0, "t4_rk0", K2);

      // Reset during round 4, then a fresh expansion
      key1 = K1; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      rk_idx1 = 4'd10;
      for (int i = 0; i < 7; i++) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("t5_busy", busy1, 0);
      check("t5_ready", keys_ready1, 0);
      check("t5_rk_out", rk_out1, 0);
      check("t5_rcon", exp_rcon1, 8'h01);
      tick();
      tick();
      check("t5_stay_idle", busy1, 0);
      key1 = K2; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      wait_done(1'b1, cyc);
      check("t5_done_cycles", cyc, 20);
      read1(4'd10, "t5_rk10", K2_R10);
      read1(4'd12, "t5_rk12", 0);
      read1(4'd15, "t5_rk15", 0);

      // Combinational expansion model
      key0 = K1; start0 = 1'b1;
      tick();
      start0 = 1'b0;
      check("t6_busy", busy0, 1);
      wait_done(1'b0, cyc);
      check("t6_done_cycles", cyc, 10);
      check("t6_ready", keys_ready0, 1);
      rk_idx0 = 4'd0;  tick(); check("t6_rk0", rk_out0, K1);
      rk_idx0 = 4'd1;  tick(); check("t6_rk1", rk_out0, K1_R1);
      rk_idx0 = 4'd10; tick(); check("t6_rk10", rk_out0, K1_R10);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/aes_round_key_sched.md
Name: aes_round_key_sched

Overview:
Sequencer that sits directly downstream of key_expansion and drives it round by round. It feeds the cipher key into key_expansion, supplies the round constant, and captures each returned round key into an 11-entry round-key store. Once all keys are stored, the cipher datapath reads any round key by index. Feedback path: each captured key_out becomes the next round's key_in.

Parameters:
EXP_LATENCY, 1, cycles from stable exp_key_in/exp_rcon to valid exp_key_out (0 = combinational, 1 = registered on CLK)
NUM_ROUNDS, 10, number of expansion rounds (AES-128); store depth = NUM_ROUNDS+1

Ports:
CLK  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
start  in  1  single-cycle request to expand key_in
key_in  in  128  cipher key, sampled on the accepting edge
busy  out  1  expansion in progress
keys_ready  out  1  all 11 round keys valid
done  out  1  one-cycle pulse when expansion completes
rk_idx  in  4  round-key read index 0..10
rk_out  out  128  round key selected by rk_idx, registered
exp_key_in  out  128  to key_expansion key_in
exp_rcon  out  8  to key_expansion r_i
exp_key_out  in  128  from key_expansion key_out

Behaviour:
- Reset (synchronous, highest priority, also mid-operation): state IDLE; busy=0, keys_ready=0, done=0, rk_out=0, exp_key_in=0, exp_rcon=8'h01, round=0, cnt=0. Store contents are don't-care after reset; keys_ready=0 hides them.
- FSM states: IDLE, EXPAND, READY.
- IDLE/READY with start=1:
  - rk[0]<=key_in, exp_key_in<=key_in, exp_rcon<=8'h01, round<=1, cnt<=0.
  - keys_ready<=0, busy<=1, next state EXPAND.
  - Restarting from READY invalidates the old keys immediately.
- EXPAND:
  - exp_key_in and exp_rcon are held stable while cnt<EXP_LATENCY; cnt increments each cycle.
  - At cnt==EXP_LATENCY: rk[round]<=exp_key_out, exp_key_in<=exp_key_out, exp_rcon<=xtime(exp_rcon), round++, cnt<=0.
  - xtime(x) = {x[6:0],1'b0} ^ (x[7] ? 8'h1B : 8'h00). Sequence: 01,02,04,08,10,20,40,80,1B,36.
  - Each round takes EXP_LATENCY+1 cycles.
  - When the capture is for round==NUM_ROUNDS: next state READY; busy<=0, keys_ready<=1, done<=1 for exactly one cycle.
  - With EXP_LATENCY=1, done and keys_ready are first visible 20 cycles after the start-accepting edge.
- start while in EXPAND: ignored, with no effect on the sequence.
- Read port:
  - rk_out <= (keys_ready && rk_idx<=10) ? rk[rk_idx] : 0.
  - Latency is 1 cycle; rk_idx 11..15 returns 0.
  - Reads during EXPAND return 0.
- The final exp_rcon value after round 10 is don't-care; it is reloaded on the next start.

Test Plan:
- Reset, then start with key_in=000102030405060708090a0b0c0d0e0f, EXP_LATENCY=1 -> busy=1 next cycle; done is a single pulse after 20 cycles; keys_ready=1 and stays 1.
- After the previous test, rk_idx=0,1,10 -> rk_out=000102030405060708090a0b0c0d0e0f, d6aa74fdd2af72fadaa678f1d6ab76fe, 13111d7fe3944a17f307a78b4d2b30c5, each one cycle after the index is applied.
- Monitor exp_rcon across one expansion -> exact sequence 01,02,04,08,10,20,40,80,1B,36, with each value held EXP_LATENCY+1 cycles.
- Key 2b7e151628aed2a6abf7158809cf4f3c, then rk_idx=10 -> d014f9a8c9ee2589e13f0cc8b6630ca6. Pulse start again at cycle 5 of expansion -> ignored, result unchanged.
- Assert reset at round 4, then release -> busy=0, keys_ready=0, rk_out=0. A fresh start then yields correct keys. rk_idx=12 after completion -> rk_out=0.
- EXP_LATENCY=0 build with combinational expansion model -> done after 10 cycles; keys match the first test.
